// File: rtl/stream_checker.sv
// Stream sink that checks COUNT accepted words against a locally regenerated xorshift32 sequence.
// Optional pseudo-random backpressure is enabled by defining STREAM_CHECKER_STALL_EN.
module stream_checker #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [31:0] SEED       = 32'h92D68CA2,
  parameter int unsigned COUNT      = 128,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [31:0] STALL_SEED = 32'h12345679
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [15:0]      err_count,
  output logic [31:0]      word_count,
  output logic [31:0]      first_bad_index,
  output logic [WIDTH-1:0] first_bad_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_start_run;
  logic [31:0]      r_expected;
  logic [31:0]      r_idle_cnt;
  logic [31:0]      w_idle_inc;
  logic             w_idle_expire;
  logic             w_stall;
  logic             w_run;
  logic             w_transfer;
  logic             w_last;
  logic             w_mismatch;

  function automatic logic [31:0] f_xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

`ifdef STREAM_CHECKER_STALL_EN
  logic [31:0] r_stall_gen;
  assign w_stall = (r_stall_gen[1:0] == 2'b00);
`else
  logic w_unused_stall_seed;
  assign w_unused_stall_seed = ^STALL_SEED;
  assign w_stall = 1'b0;
`endif

  assign w_run         = (r_state == S_RUN);
  assign in_ready      = w_run & ~w_stall;
  assign w_transfer    = in_ready & in_valid;
  assign w_last        = (word_count == 32'(COUNT - 1));
  assign w_mismatch    = w_transfer & (in_data != r_expected[WIDTH-1:0]);
  assign w_idle_inc    = r_idle_cnt + 32'd1;
  // Only source-side idleness ages the counter; checker-induced stalls leave it untouched.
  assign w_idle_expire = w_run & ~in_valid & (w_idle_inc == 32'(TIMEOUT));

  assign busy = w_run;
  assign done = (r_state == S_DONE);
  assign pass = done & (err_count == 16'd0) & ~timeout;

  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_start_run  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_transfer && w_last) begin
          w_state_next = S_DONE;
        end else if (w_idle_expire) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_start_run  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_expected      <= SEED;
      r_idle_cnt      <= '0;
      timeout         <= 1'b0;
      err_count       <= '0;
      word_count      <= '0;
      first_bad_index <= '1;
      first_bad_data  <= '0;
`ifdef STREAM_CHECKER_STALL_EN
      r_stall_gen     <= STALL_SEED;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_start_run) begin
        r_expected      <= SEED;
        r_idle_cnt      <= '0;
        timeout         <= 1'b0;
        err_count       <= '0;
        word_count      <= '0;
        first_bad_index <= '1;
        first_bad_data  <= '0;
`ifdef STREAM_CHECKER_STALL_EN
        r_stall_gen     <= STALL_SEED;
`endif
      end else if (w_run) begin
`ifdef STREAM_CHECKER_STALL_EN
        r_stall_gen <= f_xorshift32(r_stall_gen);
`endif
        if (w_transfer) begin
          word_count <= word_count + 32'd1;
          r_expected <= f_xorshift32(r_expected);
          r_idle_cnt <= '0;
          if (w_mismatch) begin
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
            // err_count never returns to zero within a run, so zero marks the first miss.
            if (err_count == 16'd0) begin
              first_bad_index <= word_count;
              first_bad_data  <= in_data;
            end
          end
        end else if (!in_valid) begin
          r_idle_cnt <= w_idle_inc;
          if (w_idle_expire) begin
            timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// Directed self-checking bench for stream_checker: matching run, corruption, timeout,
// restart, ignored start, backpressure pattern and mid-run reset.
module tb_stream_checker;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT   = 128;
  localparam int unsigned TO    = 16;
  localparam logic [31:0] SEED  = 32'h92D68CA2;
  localparam logic [31:0] SSEED = 32'h12345679;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [15:0]   err_count;
  logic [31:0]   word_count;
  logic [31:0]   first_bad_index;
  logic [W-1:0]  first_bad_data;

  int n_chk  = 0;
  int n_fail = 0;

  stream_checker #(
    .WIDTH(W), .SEED(SEED), .COUNT(CNT), .TIMEOUT(TO), .STALL_SEED(SSEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .word_count(word_count),
    .first_bad_index(first_bad_index), .first_bad_data(first_bad_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] word_at(input int k);
    logic [31:0] e;
    e = SEED;
    for (int i = 0; i < k; i++) e = xs(e);
    return e;
  endfunction

  // Called #1 after a posedge; leaves the bench #1 after the next posedge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Source: presents words first..first+n-1, optionally corrupting index bad; bounded.
  task automatic drive_stream(input int n, input int bad, input int first, output int cycles);
    logic [31:0] e;
    logic t;
    int idx;
    e = word_at(first);
    idx = first;
    cycles = 0;
    while (idx < first + n && cycles < 2000) begin
      in_valid = 1'b1;
      in_data  = (idx == bad) ? (e[W-1:0] ^ 1) : e[W-1:0];
      t = in_ready;
      @(posedge clk); #1;
      cycles++;
      if (t) begin
        idx++;
        e = xs(e);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0h expected 0", in_ready); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h expected 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0h expected 0", done); end
    n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %0h expected 0", pass); end
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %0h expected 0", timeout); end
    n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL rst_err: got %0h expected 0", err_count); end
    n_chk++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL rst_wc: got %0h expected 0", word_count); end
    n_chk++; if (first_bad_index !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rst_fbi: got %0h expected ffffffff", first_bad_index); end
    n_chk++; if (first_bad_data !== '0) begin n_fail++; $display("FAIL rst_fbd: got %0h expected 0", first_bad_data); end
  endtask

  task automatic test_match();
    int cyc;
    pulse_start();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL match_busy: got %0h expected 1", busy); end
    drive_stream(CNT, -1, 0, cyc);
`ifndef STREAM_CHECKER_STALL_EN
    n_chk++; if (cyc != CNT) begin n_fail++; $display("FAIL match_cycles: got %0d expected %0d", cyc, CNT); end
`endif
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL match_done: got %0h expected 1", done); end
    n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL match_pass: got %0h expected 1", pass); end
    n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL match_err: got %0h expected 0", err_count); end
    n_chk++; if (word_count !== 32'd128) begin n_fail++; $display("FAIL match_wc: got %0d expected 128", word_count); end
    n_chk++; if (first_bad_index !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL match_fbi: got %0h expected ffffffff", first_bad_index); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL match_ready_off: got %0h expected 0", in_ready); end
    // Words offered in DONE must not be counted.
    in_valid = 1'b1; in_data = '0;
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0;
    n_chk++; if (word_count !== 32'd128) begin n_fail++; $display("FAIL done_hold_wc: got %0d expected 128", word_count); end
    n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_hold: got done=%0h busy=%0h expected done=1 busy=0", done, busy); end
  endtask

  task automatic test_corrupt();
    int cyc;
    logic [31:0] w5;
    w5 = word_at(5);
    pulse_start();
    drive_stream(CNT, 5, 0, cyc);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL corrupt_done: got %0h expected 1", done); end
    n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL corrupt_pass: got %0h expected 0", pass); end
    n_chk++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL corrupt_err: got %0d expected 1", err_count); end
    n_chk++; if (first_bad_index !== 32'd5) begin n_fail++; $display("FAIL corrupt_fbi: got %0h expected 5", first_bad_index); end
    n_chk++; if (first_bad_data !== (w5[W-1:0] ^ 1)) begin n_fail++; $display("FAIL corrupt_fbd: got %0h expected %0h", first_bad_data, w5[W-1:0] ^ 1); end
    n_chk++; if (word_count !== 32'd128) begin n_fail++; $display("FAIL corrupt_wc: got %0d expected 128", word_count); end
  endtask

  task automatic test_timeout();
    int cyc;
    pulse_start();
    drive_stream(10, -1, 0, cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++; if (cyc != TO) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", cyc, TO); end
    n_chk++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %0h expected 1", timeout); end
    n_chk++; if (word_count !== 32'd10) begin n_fail++; $display("FAIL timeout_wc: got %0d expected 10", word_count); end
    n_chk++; if (pass !== 1'b0) begin n_fail++; $display("FAIL timeout_pass: got %0h expected 0", pass); end
    n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL timeout_err: got %0d expected 0", err_count); end
  endtask

  task automatic test_restart_done();
    int cyc;
    pulse_start();
    n_chk++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL restart_state: got busy=%0h done=%0h expected busy=1 done=0", busy, done); end
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL restart_timeout: got %0h expected 0", timeout); end
    n_chk++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL restart_wc: got %0d expected 0", word_count); end
    n_chk++; if (first_bad_index !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL restart_fbi: got %0h expected ffffffff", first_bad_index); end
    drive_stream(CNT, -1, 0, cyc);
    n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL restart_pass: got %0h expected 1", pass); end
  endtask

  task automatic test_start_busy();
    int cyc;
    pulse_start();
    drive_stream(20, -1, 0, cyc);
    pulse_start();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busystart_busy: got %0h expected 1", busy); end
    n_chk++; if (word_count !== 32'd20) begin n_fail++; $display("FAIL busystart_wc: got %0d expected 20", word_count); end
    drive_stream(CNT - 20, -1, 20, cyc);
    n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL busystart_pass: got %0h expected 1", pass); end
    n_chk++; if (word_count !== 32'd128) begin n_fail++; $display("FAIL busystart_wc_end: got %0d expected 128", word_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] sg;
    logic [31:0] e;
    logic er;
    int idx;
    int cyc;
    int bad_ready;
    sg = SSEED; e = SEED; idx = 0; cyc = 0; bad_ready = 0;
    pulse_start();
    while (idx < CNT && cyc < 1000) begin
`ifdef STREAM_CHECKER_STALL_EN
      er = (sg[1:0] != 2'b00);
`else
      er = 1'b1;
`endif
      in_valid = 1'b1;
      in_data  = e[W-1:0];
      n_chk++;
      if (in_ready !== er) begin
        n_fail++;
        $display("FAIL bp_ready cycle %0d: got %0h expected %0h", cyc, in_ready, er);
      end
      @(posedge clk); #1;
      cyc++;
      if (er) begin idx++; e = xs(e); end
      sg = xs(sg);
    end
    in_valid = 1'b0;
`ifndef STREAM_CHECKER_STALL_EN
    n_chk++; if (cyc != CNT) begin n_fail++; $display("FAIL bp_cycles: got %0d expected %0d", cyc, CNT); end
`endif
    n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL bp_pass: got %0h expected 1", pass); end
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %0h expected 0", timeout); end
    n_chk++; if (word_count !== 32'd128) begin n_fail++; $display("FAIL bp_wc: got %0d expected 128", word_count); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    pulse_start();
    drive_stream(64, 3, 0, cyc);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got busy=%0h ready=%0h expected 0 0", busy, in_ready); end
    n_chk++; if (done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got done=%0h pass=%0h expected 0 0", done, pass); end
    n_chk++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL midrst_wc: got %0d expected 0", word_count); end
    n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL midrst_err: got %0d expected 0", err_count); end
    n_chk++; if (first_bad_index !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL midrst_fbi: got %0h expected ffffffff", first_bad_index); end
    n_chk++; if (first_bad_data !== '0) begin n_fail++; $display("FAIL midrst_fbd: got %0h expected 0", first_bad_data); end
    pulse_start();
    drive_stream(CNT, -1, 0, cyc);
    n_chk++; if (pass !== 1'b1) begin n_fail++; $display("FAIL midrst_pass: got %0h expected 1", pass); end
    n_chk++; if (word_count !== 32'd128) begin n_fail++; $display("FAIL midrst_wc_end: got %0d expected 128", word_count); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    test_reset();
    test_match();
    test_corrupt();
    test_timeout();
    test_restart_done();
    test_start_busy();
    test_backpressure();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
